// File: rtl/icache_pkg.sv
// Shared I-cache definitions.
//  - refill_state_t : refill engine FSM states
//  - calc_offset_width / calc_cache_width : line geometry helpers, used by
//    the refill engine and by the I-cache so both sides agree on line layout.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } refill_state_t;

    // Number of byte-offset bits inside one cache line.
    function automatic int calc_offset_width(input int data_width, input int block_size);
        return $clog2((data_width * block_size) / 8);
    endfunction

    // Width in bits of one complete cache line.
    function automatic int calc_cache_width(input int data_width, input int block_size);
        return data_width * block_size;
    endfunction

endpackage

// File: rtl/icache_refill_engine_line_buffer.sv
// refill_line_buffer
//  Storage for one cache line being refilled: block_size words of data_width
//  bits, written one word at a time and read as one flat line.
//  Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears every word)
//   wr_en     : write strobe for one word
//   wr_sel    : index of the word to write
//   wr_data   : word to write
//   line      : flat line, word k at [k*data_width +: data_width]
module refill_line_buffer
    import icache_pkg::*;
#(
    parameter int  data_width = 32,
    parameter int  block_size = 32,
    localparam int sel_width  = $clog2(block_size),
    localparam int line_width = calc_cache_width(data_width, block_size)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [sel_width-1:0]  wr_sel,
    input  logic [data_width-1:0] wr_data,
    output logic [line_width-1:0] line
);

    logic [data_width-1:0] words_r [block_size];

    // Word storage: cleared on reset, one word written per strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < block_size; k++) begin
                words_r[k] <= {data_width{1'b0}};
            end
        end else if (wr_en) begin
            words_r[wr_sel] <= wr_data;
        end
    end

    // Flatten the word array into the line read port.
    for (genvar k = 0; k < block_size; k++) begin : g_flat
        assign line[k*data_width +: data_width] = words_r[k];
    end

endmodule

// File: rtl/icache_refill_engine.sv
// icache_refill_engine
//  Line-refill engine behind the I-cache miss port. A one-cycle miss request
//  is turned into one burst read of block_size beats; the beats are assembled
//  into a line that is handed back with a one-cycle valid pulse.
//  Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   ADDR_TO_L2_VALID    : miss request pulse (accepted only when idle)
//   ADDR_TO_L2          : line address of the miss
//   DATA_FROM_L2        : assembled line, word k at [k*data_width +: data_width]
//   DATA_FROM_L2_VALID  : one-cycle line-valid pulse
//   L2_ACCESS_FAULT     : error summary, valid together with the line pulse
//   BUSY                : refill in progress (capture through valid pulse)
//   MEM_AR*             : burst read request channel
//   MEM_R*              : read beat channel (ready is implicitly always high)
//  Every output comes from a register; no input reaches an output
//  combinationally.
module icache_refill_engine
    import icache_pkg::*;
#(
    parameter int  data_width    = 32,
    parameter int  address_width = 32,
    parameter int  block_size    = 32,
    localparam int offset_width  = calc_offset_width(data_width, block_size),
    localparam int cache_width   = calc_cache_width(data_width, block_size)
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              ADDR_TO_L2_VALID,
    input  logic [address_width-offset_width-1:0] ADDR_TO_L2,
    output logic [cache_width-1:0]            DATA_FROM_L2,
    output logic                              DATA_FROM_L2_VALID,
    output logic                              L2_ACCESS_FAULT,
    output logic                              BUSY,
    output logic                              MEM_ARVALID,
    input  logic                              MEM_ARREADY,
    output logic [address_width-1:0]          MEM_ARADDR,
    output logic [7:0]                        MEM_ARLEN,
    input  logic                              MEM_RVALID,
    input  logic [data_width-1:0]             MEM_RDATA,
    input  logic                              MEM_RERR,
    input  logic                              MEM_RLAST
);

    localparam int cnt_width       = $clog2(block_size);
    localparam int line_addr_width = address_width - offset_width;
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'(block_size - 1);
    localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);

    refill_state_t              state_r;
    refill_state_t              state_nx_s;
    logic [line_addr_width-1:0] addr_r;
    logic [cnt_width-1:0]       cnt_r;
    logic [cnt_width-1:0]       cnt_nx_s;
    logic                       err_r;
    logic                       err_nx_s;
    logic                       beat_s;
    logic                       rlast_bad_s;
    logic                       arvalid_r;
    logic                       busy_r;
    logic                       valid_r;
    logic                       fault_r;

    // A beat is consumed only while collecting data; RVALID elsewhere is noise.
    assign beat_s = (state_r == DATA) && MEM_RVALID;

    // The beat count is authoritative: RLAST must appear exactly on the final
    // counted beat, anything else is a protocol error folded into the fault.
    assign rlast_bad_s = (cnt_r == cnt_last) ? ~MEM_RLAST : MEM_RLAST;

    // Next-state, beat counter and error flag update.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        err_nx_s   = err_r;
        case (state_r)
            IDLE: begin
                if (ADDR_TO_L2_VALID) begin
                    state_nx_s = REQ;
                    cnt_nx_s   = {cnt_width{1'b0}};
                    err_nx_s   = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (MEM_ARREADY) begin
                    state_nx_s = DATA;
                end else begin
                    state_nx_s = REQ;
                end
            end
            DATA: begin
                if (MEM_RVALID) begin
                    err_nx_s = err_r | MEM_RERR | rlast_bad_s;
                    if (cnt_r == cnt_last) begin
                        state_nx_s = RESP;
                        cnt_nx_s   = {cnt_width{1'b0}};
                    end else begin
                        state_nx_s = DATA;
                        cnt_nx_s   = cnt_r + cnt_one;
                    end
                end else begin
                    state_nx_s = DATA;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {cnt_width{1'b0}};
                err_nx_s   = 1'b0;
            end
        endcase
    end

    // FSM state, beat counter and error flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= {cnt_width{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            err_r   <= err_nx_s;
        end
    end

    // Line address capture; held stable for the whole refill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_r <= {line_addr_width{1'b0}};
        end else if ((state_r == IDLE) && ADDR_TO_L2_VALID) begin
            addr_r <= ADDR_TO_L2;
        end
    end

    // Output flags registered from the next state so they line up with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            arvalid_r <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            arvalid_r <= (state_nx_s == REQ);
            busy_r    <= (state_nx_s != IDLE);
            valid_r   <= (state_nx_s == RESP);
            fault_r   <= (state_nx_s == RESP) & err_nx_s;
        end
    end

    refill_line_buffer #(
        .data_width (data_width),
        .block_size (block_size)
    ) u_line_buffer (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (beat_s),
        .wr_sel  (cnt_r),
        .wr_data (MEM_RDATA),
        .line    (DATA_FROM_L2)
    );

    assign MEM_ARVALID        = arvalid_r;
    assign MEM_ARADDR         = {addr_r, {offset_width{1'b0}}};
    assign MEM_ARLEN          = 8'(block_size - 1);
    assign BUSY               = busy_r;
    assign DATA_FROM_L2_VALID = valid_r;
    assign L2_ACCESS_FAULT    = fault_r;

endmodule

// File: tb/tb_icache_refill_engine.sv
module tb_icache_refill_engine;

    logic         CLK;
    logic         RST;
    logic         ADDR_TO_L2_VALID;
    logic [24:0]  ADDR_TO_L2;
    logic [1023:0] DATA_FROM_L2;
    logic         DATA_FROM_L2_VALID;
    logic         L2_ACCESS_FAULT;
    logic         BUSY;
    logic         MEM_ARVALID;
    logic         MEM_ARREADY = 1'b0;
    logic [31:0]  MEM_ARADDR;
    logic [7:0]   MEM_ARLEN;
    logic         MEM_RVALID  = 1'b0;
    logic [31:0]  MEM_RDATA   = 32'h0;
    logic         MEM_RERR    = 1'b0;
    logic         MEM_RLAST   = 1'b0;

    icache_refill_engine dut (
        .CLK                (CLK),
        .RST                (RST),
        .ADDR_TO_L2_VALID   (ADDR_TO_L2_VALID),
        .ADDR_TO_L2         (ADDR_TO_L2),
        .DATA_FROM_L2       (DATA_FROM_L2),
        .DATA_FROM_L2_VALID (DATA_FROM_L2_VALID),
        .L2_ACCESS_FAULT    (L2_ACCESS_FAULT),
        .BUSY               (BUSY),
        .MEM_ARVALID        (MEM_ARVALID),
        .MEM_ARREADY        (MEM_ARREADY),
        .MEM_ARADDR         (MEM_ARADDR),
        .MEM_ARLEN          (MEM_ARLEN),
        .MEM_RVALID         (MEM_RVALID),
        .MEM_RDATA          (MEM_RDATA),
        .MEM_RERR           (MEM_RERR),
        .MEM_RLAST          (MEM_RLAST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [24:0] addr;
        logic [31:0] araddr;
        logic [31:0] base;
        int          ar_delay;
        bit          toggle;
        int          err_beat;
        int          rlast_beat;
        int          busy_at;
        bit          resp_req;
        bit          noise;
        bit          fault;
        int          lat;
    } vec_t;

    vec_t vecs [7];
    vec_t vpost;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // memory responder configuration and state
    int          m_ar_delay  = 0;
    int          m_err_beat  = 99;
    int          m_rlast_beat = 31;
    int          m_phase     = 0;
    int          m_wait      = 0;
    int          m_beat      = 0;
    bit          m_toggle    = 1'b0;
    bit          m_tog       = 1'b1;
    bit          m_noise     = 1'b0;
    logic [31:0] m_base      = 32'h0;

    // memory responder: answers the AR handshake, then streams 32 beats
    always @(negedge CLK) begin
        if (RST) begin
            m_phase     = 0;
            m_beat      = 0;
            MEM_ARREADY = 1'b0;
        end else begin
            if (m_phase == 0 && MEM_ARVALID) begin
                m_phase = 1;
                m_wait  = 0;
            end
            if (m_phase == 1) begin
                if (MEM_ARREADY) begin
                    MEM_ARREADY = 1'b0;
                    m_phase     = 2;
                    m_beat      = 0;
                    m_tog       = 1'b1;
                end else if (m_wait >= m_ar_delay) begin
                    MEM_ARREADY = 1'b1;
                end else begin
                    m_wait++;
                end
            end
            if (m_phase == 2) begin
                if (m_beat >= 32) begin
                    m_phase = 0;
                end else if (!m_toggle || m_tog) begin
                    MEM_RVALID = 1'b1;
                    MEM_RDATA  = m_base + 32'(m_beat);
                    MEM_RERR   = (m_beat == m_err_beat);
                    MEM_RLAST  = (m_beat == m_rlast_beat);
                    m_beat++;
                    m_tog      = 1'b0;
                end else begin
                    MEM_RVALID = 1'b0;
                    MEM_RDATA  = 32'hBAD0_0000;
                    MEM_RERR   = 1'b1;
                    MEM_RLAST  = 1'b1;
                    m_tog      = 1'b1;
                end
            end
        end
        if (m_phase != 2) begin
            MEM_RVALID = m_noise;
            MEM_RDATA  = 32'hDEAD_BEEF;
            MEM_RERR   = m_noise;
            MEM_RLAST  = m_noise;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // compares a line against word k = base + k, reporting the first bad word
    task automatic check_line(input string name, input logic [1023:0] l, input logic [31:0] base);
        int bad_k;
        bad_k = -1;
        for (int k = 0; k < 32; k++) begin
            if (bad_k < 0 && l[k*32 +: 32] !== base + 32'(k)) bad_k = k;
        end
        if (bad_k < 0) bad_k = 0;
        check($sformatf("%s word%0d", name, bad_k), {32'h0, l[bad_k*32 +: 32]}, {32'h0, base + 32'(bad_k)});
    endtask

    task automatic run_refill(input vec_t v, input int id);
        int            lat;
        int            arv;
        bit            addr_bad;
        bit            busy_bad;
        bit            seen;
        logic          fault;
        logic [1023:0] line;
        int            extra_v;
        int            extra_ar;
        int            extra_busy;
        m_base       = v.base;
        m_ar_delay   = v.ar_delay;
        m_toggle     = v.toggle;
        m_err_beat   = v.err_beat;
        m_rlast_beat = v.rlast_beat;
        m_noise      = v.noise;
        fault        = 1'b0;
        line         = '0;
        @(negedge CLK);
        ADDR_TO_L2       = v.addr;
        ADDR_TO_L2_VALID = 1'b1;
        @(negedge CLK);
        lat = 1; arv = 0; addr_bad = 0; busy_bad = 0; seen = 0;
        while (!seen && lat < 300) begin
            ADDR_TO_L2_VALID = 1'b0;
            if (MEM_ARVALID) begin
                arv++;
                if (MEM_ARADDR !== v.araddr) addr_bad = 1'b1;
            end
            if (BUSY !== 1'b1) busy_bad = 1'b1;
            if (DATA_FROM_L2_VALID === 1'b1) begin
                seen  = 1'b1;
                fault = L2_ACCESS_FAULT;
                line  = DATA_FROM_L2;
            end else begin
                if (v.busy_at != 0 && lat == v.busy_at) begin
                    ADDR_TO_L2       = 25'h1FF_FFFF;
                    ADDR_TO_L2_VALID = 1'b1;
                end
                @(negedge CLK);
                lat++;
            end
        end
        check($sformatf("v%0d valid seen", id), 64'(seen), 64'd1);
        check($sformatf("v%0d latency", id), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d arvalid cycles", id), 64'(arv), 64'(v.ar_delay + 1));
        check($sformatf("v%0d araddr stable", id), 64'(addr_bad), 64'd0);
        check($sformatf("v%0d busy held", id), 64'(busy_bad), 64'd0);
        check($sformatf("v%0d fault", id), 64'(fault), 64'(v.fault));
        check_line($sformatf("v%0d line", id), line, v.base);
        if (v.resp_req) begin
            ADDR_TO_L2       = 25'h0AA_AAAA;
            ADDR_TO_L2_VALID = 1'b1;
        end
        extra_v = 0; extra_ar = 0; extra_busy = 0;
        repeat (4) begin
            @(negedge CLK);
            ADDR_TO_L2_VALID = 1'b0;
            if (DATA_FROM_L2_VALID !== 1'b0) extra_v++;
            if (MEM_ARVALID !== 1'b0) extra_ar++;
            if (BUSY !== 1'b0) extra_busy++;
        end
        check($sformatf("v%0d extra valid", id), 64'(extra_v), 64'd0);
        check($sformatf("v%0d extra arvalid", id), 64'(extra_ar), 64'd0);
        check($sformatf("v%0d busy after", id), 64'(extra_busy), 64'd0);
        check_line($sformatf("v%0d line hold", id), DATA_FROM_L2, v.base);
    endtask

    initial begin
        int w;
        //           addr          araddr        base          ard tog err rlast busy rreq noise flt lat
        vecs[0] = '{25'h100_0000, 32'h8000_0000, 32'h0000_1000, 0, 1'b0, 99, 31,  0, 1'b0, 1'b0, 1'b0, 34};
        vecs[1] = '{25'h000_0123, 32'h0000_9180, 32'h0000_2000, 5, 1'b1, 99, 31,  0, 1'b0, 1'b0, 1'b0, 70};
        vecs[2] = '{25'h1AB_CDEF, 32'hD5E6_F780, 32'h0000_3000, 0, 1'b0,  7, 31,  0, 1'b0, 1'b1, 1'b1, 34};
        vecs[3] = '{25'h000_0001, 32'h0000_0080, 32'h0000_4000, 0, 1'b0, 99, 31,  0, 1'b0, 1'b1, 1'b0, 34};
        vecs[4] = '{25'h0FF_FFFF, 32'h7FFF_FF80, 32'h0000_5000, 0, 1'b0, 99, 31, 10, 1'b1, 1'b0, 1'b0, 34};
        vecs[5] = '{25'h040_0000, 32'h2000_0000, 32'h0000_A000, 0, 1'b0, 99, 10,  0, 1'b0, 1'b0, 1'b1, 34};
        vecs[6] = '{25'h000_0002, 32'h0000_0100, 32'h0000_B000, 2, 1'b1, 99, 99,  0, 1'b0, 1'b0, 1'b1, 67};
        vpost   = '{25'h155_5555, 32'hAAAA_AA80, 32'h0000_C000, 1, 1'b0, 99, 31,  0, 1'b0, 1'b0, 1'b0, 35};

        RST              = 1'b1;
        ADDR_TO_L2_VALID = 1'b0;
        ADDR_TO_L2       = 25'h0;
        repeat (3) @(negedge CLK);
        check("reset valid", 64'(DATA_FROM_L2_VALID), 64'd0);
        check("reset fault", 64'(L2_ACCESS_FAULT), 64'd0);
        check("reset busy", 64'(BUSY), 64'd0);
        check("reset arvalid", 64'(MEM_ARVALID), 64'd0);
        check("reset line zero", 64'(DATA_FROM_L2 == '0), 64'd1);
        check("arlen", 64'(MEM_ARLEN), 64'd31);
        RST = 1'b0;
        @(negedge CLK);
        check("idle busy", 64'(BUSY), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_refill(vecs[i], i);
        end

        // asynchronous reset in the middle of a burst
        m_base = 32'h0000_6000; m_ar_delay = 0; m_toggle = 1'b0;
        m_err_beat = 99; m_rlast_beat = 31; m_noise = 1'b0;
        @(negedge CLK);
        ADDR_TO_L2       = 25'h000_0ABC;
        ADDR_TO_L2_VALID = 1'b1;
        @(negedge CLK);
        ADDR_TO_L2_VALID = 1'b0;
        w = 0;
        while (m_beat < 12 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        check("rst reached beat 12", 64'(w < 100), 64'd1);
        @(posedge CLK);
        #1;
        check("rst busy before", 64'(BUSY), 64'd1);
        #1;
        RST = 1'b1;
        #1;
        check("rst arvalid", 64'(MEM_ARVALID), 64'd0);
        check("rst valid", 64'(DATA_FROM_L2_VALID), 64'd0);
        check("rst fault", 64'(L2_ACCESS_FAULT), 64'd0);
        check("rst busy", 64'(BUSY), 64'd0);
        check("rst line zero", 64'(DATA_FROM_L2 == '0), 64'd1);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        run_refill(vpost, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
